// File: rtl/trap_seq_ctrl.sv
// trap_seq_ctrl
//   Machine-mode trap sequencer for the single-issue RV32 core. Owns the trap
//   CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause), detects
//   ecall/ebreak/mret and enabled interrupts at instruction boundaries,
//   stalls/squashes decode, updates the CSRs and redirects fetch.
//
// Ports
//   clk, rst                   core clock, synchronous active-high reset
//   instr, instr_valid, pc     decode-stage instruction, valid and its address
//   irq_timer, irq_ext         level interrupt requests
//   csr_wr_en/addr/data        software CSR write port
//   csr_rd_addr, csr_rd_data   combinational CSR read port (0 if unmapped)
//   stall, squash              pipeline hold / kill of the decode instruction
//   redirect, redirect_pc      one-cycle fetch redirect and its target
//   busy                       sequencer not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | watching decode for traps, interrupts and mret
// ENTER | trap entry: save pc/cause, stack MIE, target <= mtvec
// LEAVE | trap return: restore MIE, target <= mepc
// JUMP  | pulse redirect to target, then release the stall

module trap_seq_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        csr_wr_en,
    input  logic [11:0] csr_wr_addr,
    input  logic [31:0] csr_wr_data,
    input  logic [11:0] csr_rd_addr,
    output logic [31:0] csr_rd_data,
    output logic        stall,
    output logic        squash,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        LEAVE = 2'd2,
        JUMP  = 2'd3
    } state_t;

    state_t      state, state_nxt;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_mtie;
    logic        mie_meie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] target;
    logic [31:0] pc_lat;
    logic [31:0] cause_lat;

    logic        take_trap;
    logic        take_mret;
    logic [31:0] cause_nxt;
    logic        csr_wr_ok;

    // Take decision, priority-ordered. Only meaningful in IDLE with a valid
    // instruction; anything outside that window is ignored.
    always_comb begin
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause_nxt = 32'h0;
        if (state == IDLE && instr_valid) begin
            if (irq_ext && mie_meie && mstatus_mie) begin
                take_trap = 1'b1;
                cause_nxt = 32'h8000_000B;
            end else if (irq_timer && mie_mtie && mstatus_mie) begin
                take_trap = 1'b1;
                cause_nxt = 32'h8000_0007;
            end else if (instr == INSTR_ECALL) begin
                take_trap = 1'b1;
                cause_nxt = 32'd11;
            end else if (instr == INSTR_EBREAK) begin
                take_trap = 1'b1;
                cause_nxt = 32'd3;
            end else if (instr == INSTR_MRET) begin
                take_mret = 1'b1;
            end
        end
    end

    // A write riding on a squashed instruction must not land.
    assign csr_wr_ok = csr_wr_en && (state == IDLE) && !take_trap && !take_mret;

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        squash      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        unique case (state)
            IDLE: begin
                if (take_trap) begin
                    stall     = 1'b1;
                    squash    = 1'b1;
                    state_nxt = ENTER;
                end else if (take_mret) begin
                    stall     = 1'b1;
                    squash    = 1'b1;
                    state_nxt = LEAVE;
                end
            end
            ENTER: begin
                stall     = 1'b1;
                state_nxt = JUMP;
            end
            LEAVE: begin
                stall     = 1'b1;
                state_nxt = JUMP;
            end
            JUMP: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = target;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= RESET_MTVEC;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
            target       <= 32'h0;
            pc_lat       <= 32'h0;
            cause_lat    <= 32'h0;
        end else begin
            if (take_trap) begin
                pc_lat    <= pc;
                cause_lat <= cause_nxt;
            end

            if (state == ENTER) begin
                mepc         <= pc_lat;
                mcause       <= cause_lat;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                target       <= {mtvec[31:2], 2'b00};
            end else if (state == LEAVE) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                target       <= {mepc[31:2], 2'b00};
            end else if (csr_wr_ok) begin
                unique case (csr_wr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= csr_wr_data[3];
                        mstatus_mpie <= csr_wr_data[7];
                    end
                    ADDR_MIE: begin
                        mie_mtie <= csr_wr_data[7];
                        mie_meie <= csr_wr_data[11];
                    end
                    ADDR_MTVEC:  mtvec  <= csr_wr_data;
                    ADDR_MEPC:   mepc   <= csr_wr_data;
                    ADDR_MCAUSE: mcause <= csr_wr_data;
                    default: ;
                endcase
            end
        end
    end

    // Low bits of mtvec/mepc are stored as written but always read back as 0.
    always_comb begin
        csr_rd_data = 32'h0;
        unique case (csr_rd_addr)
            ADDR_MSTATUS: begin
                csr_rd_data[3]     = mstatus_mie;
                csr_rd_data[7]     = mstatus_mpie;
                csr_rd_data[12:11] = 2'b11;
            end
            ADDR_MIE: begin
                csr_rd_data[7]  = mie_mtie;
                csr_rd_data[11] = mie_meie;
            end
            ADDR_MTVEC:  csr_rd_data = {mtvec[31:2], 2'b00};
            ADDR_MEPC:   csr_rd_data = {mepc[31:2], 2'b00};
            ADDR_MCAUSE: csr_rd_data = mcause;
            ADDR_MIP: begin
                csr_rd_data[7]  = irq_timer;
                csr_rd_data[11] = irq_ext;
            end
            default: csr_rd_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// tb_trap_seq_ctrl
//   Directed bench for trap_seq_ctrl. Inputs change 1 ns after each rising
//   edge; outputs are compared 1 ns later, well clear of the next edge.

module tb_trap_seq_ctrl;

    localparam logic [31:0] RST_MTVEC = 32'h0000_0043;
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] MRET      = 32'h3020_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        irq_timer;
    logic        irq_ext;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        stall;
    logic        squash;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    trap_seq_ctrl #(.RESET_MTVEC(RST_MTVEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .irq_timer   (irq_timer),
        .irq_ext     (irq_ext),
        .csr_wr_en   (csr_wr_en),
        .csr_wr_addr (csr_wr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_rd_addr (csr_rd_addr),
        .csr_rd_data (csr_rd_data),
        .stall       (stall),
        .squash      (squash),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_wr_en   = 1'b1;
        csr_wr_addr = addr;
        csr_wr_data = data;
        step();
        csr_wr_en   = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_rd_addr = addr;
        #1;
        chk(tag, csr_rd_data, exp);
    endtask

    // Presents one instruction at cycle T and follows the sequence to T+3.
    // At T+1 the decode inputs are scrambled to show the sequence ignores them.
    task automatic run_seq(input string tag, input logic [31:0] pcv,
                           input logic [31:0] iv, input logic [31:0] exp_tgt);
        instr_valid = 1'b1;
        pc          = pcv;
        instr       = iv;
        #1;
        chk({tag, ".T.squash"}, {31'h0, squash}, 32'h1);
        chk({tag, ".T.stall"},  {31'h0, stall},  32'h1);
        step();
        csr_wr_en   = 1'b0;
        instr_valid = 1'b0;
        pc          = 32'hDEAD_BEE0;
        instr       = EBREAK;
        #1;
        chk({tag, ".T1.busy"},     {31'h0, busy},     32'h1);
        chk({tag, ".T1.stall"},    {31'h0, stall},    32'h1);
        chk({tag, ".T1.redirect"}, {31'h0, redirect}, 32'h0);
        step();
        #1;
        chk({tag, ".T2.redirect"}, {31'h0, redirect}, 32'h1);
        chk({tag, ".T2.rpc"},      redirect_pc,       exp_tgt);
        step();
        instr = NOP;
        #1;
        chk({tag, ".T3.stall"}, {31'h0, stall}, 32'h0);
        chk({tag, ".T3.busy"},  {31'h0, busy},  32'h0);
        chk({tag, ".T3.rpc"},   redirect_pc,    32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        instr       = NOP;
        instr_valid = 1'b0;
        pc          = 32'h0;
        irq_timer   = 1'b0;
        irq_ext     = 1'b0;
        csr_wr_en   = 1'b0;
        csr_wr_addr = 12'h0;
        csr_wr_data = 32'h0;
        csr_rd_addr = 12'h0;
        step();
        step();
        rst = 1'b0;
        #1;

        // reset state
        chk("rst.stall",    {31'h0, stall},    32'h0);
        chk("rst.squash",   {31'h0, squash},   32'h0);
        chk("rst.redirect", {31'h0, redirect}, 32'h0);
        chk("rst.busy",     {31'h0, busy},     32'h0);
        chk("rst.rpc",      redirect_pc,       32'h0);
        csr_chk("rst.mtvec",   12'h305, 32'h0000_0040);
        csr_chk("rst.mstatus", 12'h300, 32'h0000_1800);
        csr_chk("rst.mie",     12'h304, 32'h0);
        csr_chk("rst.mepc",    12'h341, 32'h0);
        csr_chk("rst.mcause",  12'h342, 32'h0);
        csr_chk("rst.unmap",   12'h7C0, 32'h0);

        // mtvec low bits drop on read
        csr_write(12'h305, 32'h0000_0203);
        csr_chk("wr.mtvec", 12'h305, 32'h0000_0200);

        // ecall with MIE=1 beforehand
        csr_write(12'h300, 32'h0000_0008);
        csr_chk("wr.mstatus", 12'h300, 32'h0000_1808);
        run_seq("ecall", 32'h0000_0100, ECALL, 32'h0000_0200);
        csr_chk("ecall.mepc",    12'h341, 32'h0000_0100);
        csr_chk("ecall.mcause",  12'h342, 32'd11);
        csr_chk("ecall.mstatus", 12'h300, 32'h0000_1880);

        // mret back to mepc=0x104 with MPIE=1, MIE=0
        csr_write(12'h341, 32'h0000_0104);
        run_seq("mret", 32'h0000_0200, MRET, 32'h0000_0104);
        csr_chk("mret.mstatus", 12'h300, 32'h0000_1888);
        csr_chk("mret.mcause",  12'h342, 32'd11);

        // timer gated by MIE=0
        csr_write(12'h300, 32'h0000_0000);
        csr_write(12'h304, 32'h0000_0080);
        csr_chk("tmr.mie", 12'h304, 32'h0000_0080);
        irq_timer   = 1'b1;
        instr_valid = 1'b1;
        instr       = NOP;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0000_0140 + 32'(i * 4);
            #1;
            chk("tmr.gated.stall", {31'h0, stall}, 32'h0);
            step();
        end
        chk("tmr.gated.busy", {31'h0, busy}, 32'h0);
        instr_valid = 1'b0;
        csr_write(12'h300, 32'h0000_0008);
        run_seq("tmr", 32'h0000_0180, NOP, 32'h0000_0200);
        irq_timer = 1'b0;
        csr_chk("tmr.mcause",  12'h342, 32'h8000_0007);
        csr_chk("tmr.mepc",    12'h341, 32'h0000_0180);
        csr_chk("tmr.mstatus", 12'h300, 32'h0000_1880);

        // ext beats timer beats ecall; coincident mtvec write is dropped
        csr_write(12'h304, 32'h0000_0880);
        csr_write(12'h300, 32'h0000_0008);
        irq_ext     = 1'b1;
        irq_timer   = 1'b1;
        csr_wr_en   = 1'b1;
        csr_wr_addr = 12'h305;
        csr_wr_data = 32'h0000_0400;
        run_seq("sim", 32'h0000_0300, ECALL, 32'h0000_0200);
        irq_ext   = 1'b0;
        irq_timer = 1'b0;
        csr_chk("sim.mcause", 12'h342, 32'h8000_000B);
        csr_chk("sim.mepc",   12'h341, 32'h0000_0300);
        csr_chk("sim.mtvec",  12'h305, 32'h0000_0200);

        // ebreak cause
        run_seq("ebrk", 32'h0000_0310, EBREAK, 32'h0000_0200);
        csr_chk("ebrk.mcause", 12'h342, 32'd3);

        // mip is read-only and tracks the irq lines
        csr_write(12'h344, 32'hFFFF_FFFF);
        csr_chk("mip.idle", 12'h344, 32'h0);
        irq_timer = 1'b1;
        csr_chk("mip.tmr", 12'h344, 32'h0000_0080);
        irq_timer = 1'b0;
        irq_ext   = 1'b1;
        csr_chk("mip.ext", 12'h344, 32'h0000_0800);
        irq_ext   = 1'b0;

        // reset landing in ENTER
        instr_valid = 1'b1;
        pc          = 32'h0000_0500;
        instr       = ECALL;
        step();
        instr_valid = 1'b0;
        instr       = NOP;
        #1;
        chk("rstmid.busy.pre", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstmid.busy",     {31'h0, busy},     32'h0);
        chk("rstmid.redirect", {31'h0, redirect}, 32'h0);
        chk("rstmid.stall",    {31'h0, stall},    32'h0);
        csr_chk("rstmid.mepc",  12'h341, 32'h0);
        csr_chk("rstmid.mtvec", 12'h305, 32'h0000_0040);
        step();
        #1;
        chk("rstmid.redirect2", {31'h0, redirect}, 32'h0);
        chk("rstmid.busy2",     {31'h0, busy},     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
- Machine-mode trap sequencer for the single-issue RV32 core.
- Sits beside the instruction decoder. Holds the trap CSRs mstatus, mie, mip, mtvec, mepc and mcause.
- Detects ecall/ebreak/mret and enabled interrupts at instruction boundaries.
- Stalls the pipeline, sequences the CSR updates, then redirects fetch to mtvec or mepc.

Parameters:
- RESET_MTVEC, 32'h0000_0000, mtvec value loaded on reset (bits[1:0] forced 0).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction in decode stage
- instr_valid  in  1  instr/pc valid this cycle
- pc  in  32  address of instr
- irq_timer  in  1  level machine-timer interrupt
- irq_ext  in  1  level machine-external interrupt
- csr_wr_en  in  1  software CSR write strobe, from the CSR ALU path
- csr_wr_addr  in  12  CSR write address
- csr_wr_data  in  32  CSR write data
- csr_rd_addr  in  12  CSR read address
- csr_rd_data  out  32  combinational read data; 0 for unimplemented addresses
- stall  out  1  hold PC and decode stage
- squash  out  1  kill the current decode instruction (no regwr, memwr, csr write)
- redirect  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  32  redirect target
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge. It overrides everything, including mid-sequence.
- Reset values:
  - state=IDLE; target=0.
  - mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mtvec=RESET_MTVEC.
  - stall, squash, redirect, busy = 0; redirect_pc=0.
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits12:11 read 2'b11, all other bits read 0.
  - mie 0x304: bit7 MTIE, bit11 MEIE.
  - mtvec 0x305: direct mode only, bits[1:0] read 0.
  - mip 0x344: read-only, bit7=irq_timer, bit11=irq_ext.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: full 32 bits.
  - Writes to mip or unmapped addresses are ignored.
- Take conditions, evaluated in IDLE with instr_valid=1, in priority order:
  - irq_ext&MEIE&MIE → cause 32'h8000000B
  - irq_timer&MTIE&MIE → cause 32'h80000007
  - instr==32'h00000073 (ecall) → cause 11
  - instr==32'h00100073 (ebreak) → cause 3
  - instr==32'h30200073 (mret) → return
- FSM states: IDLE, ENTER, LEAVE, JUMP.
  - IDLE, trap taken (cycle T): squash=1, stall=1 combinationally; next=ENTER.
  - IDLE, mret: squash=1, stall=1; next=LEAVE.
  - ENTER (T+1): mepc<=pc latched at T; mcause<=cause latched at T; MPIE<=MIE; MIE<=0; target<=mtvec; stall=1; next=JUMP.
  - LEAVE (T+1): MIE<=MPIE; MPIE<=1; target<=mepc; stall=1; next=JUMP.
  - JUMP (T+2): redirect=1, redirect_pc=target, stall=1; next=IDLE.
  - At T+3, stall=0 and fetch resumes at target.
- pc and cause are registered at cycle T. Later changes on pc, instr or irq_* do not alter the sequence.
- Interrupts are not sampled outside IDLE. A level irq still pending and enabled at the next IDLE valid cycle is taken then.
- CSR writes:
  - Applied on the edge when csr_wr_en=1, state==IDLE and no take/mret in that cycle.
  - Ignored when the same cycle takes a trap or mret (squashed instruction). Ignored in non-IDLE states.
- ENTER/LEAVE updates to MIE/MPIE/mepc/mcause are FSM-owned; no software write can coincide with them.
- busy = (state!=IDLE). redirect_pc=0 whenever redirect=0.
- Reset during ENTER/LEAVE/JUMP: next cycle IDLE, no redirect, all CSRs at reset values.

Test Plan:
- Ecall: mtvec=0x200, ecall at pc=0x100.
  - T: squash=1, stall=1.
  - T+2: redirect=1, redirect_pc=0x200.
  - After: mepc=0x100, mcause=11, MIE=0, MPIE=prior MIE; stall low at T+3.
- Mret: mepc=0x104, MPIE=1, MIE=0; mret issued.
  - T+2: redirect_pc=0x104.
  - After: MIE=1, MPIE=1, mcause unchanged.
- Timer interrupt gating:
  - MIE=0, MTIE=1, irq_timer=1 for 10 cycles → no take.
  - Set MIE=1 → take on next valid IDLE cycle; mcause=0x80000007, mepc=pc of squashed instr.
- Simultaneous events: irq_ext and irq_timer both enabled, instr=ecall at pc=0x300 → mcause=0x8000000B, mepc=0x300, ecall not re-executed until return.
- CSR write behaviour:
  - Write 0x203 to mtvec → csr_rd_data(0x305)=0x200.
  - Write mip → read unchanged.
  - csr_wr_en in the same cycle as an interrupt take → write dropped.
- Reset asserted in ENTER → redirect never asserts, state IDLE, mepc=0, mtvec=RESET_MTVEC next cycle.
